pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the IF/ID and ID/EX stage registers and the PC.
- Generates per-cycle write-enable, flush and bubble controls for three cases: load-use hazards, multi-cycle EX operations (EX is held), and ret/redirect squashes.
- Sits beside the decode stage; its outputs gate the stage registers' capture and zero their control fields.

Parameters:
- REG_AW, 5, register-address width.
- MC_LATENCY, 4, total EX cycles a multi-cycle op occupies. Legal range is 2 or more; elaboration error otherwise.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs_a  in  REG_AW  ID source register A.
- id_rs_b  in  REG_AW  ID source register B.
- id_uses_a  in  1  ID instruction reads rs_a.
- id_uses_b  in  1  ID instruction reads rs_b.
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a data-memory load.
- ex_rd  in  REG_AW  EX destination register.
- ex_multicycle  in  1  EX op needs MC_LATENCY cycles.
- ex_ret_enable  in  1  EX op redirects the PC.
- pc_we  out  1  PC may update.
- if_id_we  out  1  IF/ID captures.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_we  out  1  ID/EX captures.
- id_ex_bubble  out  1  ID/EX captures zeroed controls (DM_WE=0, ret_enable=0, ALU_OP=0).
- ex_mc_done  out  1  one-cycle pulse; the multi-cycle result is final.
- busy  out  1  high in MC_WAIT.
- stall_count  out  CNT_W  saturating count of cycles with pc_we=0.

Behaviour:
- States: RUN, MC_WAIT, MC_DONE. State is registered; control outputs are combinational from state and inputs.
- While rst=1:
  - Outputs forced: pc_we=0, if_id_we=0, id_ex_we=0, if_id_flush=0, id_ex_bubble=0, ex_mc_done=0, busy=0.
  - Next state is RUN, mc counter=0, stall_count=0.
  - Reset mid-MC_WAIT abandons the op; the first cycle after reset is RUN.
- Load-use hazard (lu) = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_a & id_rs_a==ex_rd) | (id_uses_b & id_rs_b==ex_rd)).
- RUN, evaluated in priority order:
  1. ex_valid & ex_ret_enable:
     - pc_we=1, if_id_we=1, if_id_flush=1, id_ex_we=1, id_ex_bubble=1.
     - Stay in RUN. Redirect beats lu and multicycle.
  2. ex_valid & ex_multicycle:
     - pc_we=0, if_id_we=0, id_ex_we=0.
     - Load counter with MC_LATENCY-1; go to MC_WAIT.
  3. lu:
     - pc_we=0, if_id_we=0, id_ex_we=1, id_ex_bubble=1. One bubble, then lu clears.
  4. Otherwise: all enables 1, flush/bubble 0.
- MC_WAIT:
  - pc_we=0, if_id_we=0, id_ex_we=0, busy=1; all inputs are ignored.
  - Counter decrements each cycle. When counter==1, go to MC_DONE.
  - Stall length is MC_LATENCY cycles in total (detect cycle plus MC_LATENCY-1 wait cycles).
- MC_DONE:
  - ex_mc_done=1, pc_we=1, if_id_we=1, id_ex_we=1.
  - ex_multicycle is ignored, so the held op does not retrigger. Redirect and lu are evaluated as in RUN.
  - Next state is RUN.
- stall_count increments on every non-reset cycle with pc_we=0 and saturates at all-ones.
- ex_rd==0 never produces a hazard.
- id_valid=0 suppresses lu.
- ex_valid=0 suppresses all EX-originated actions.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, MC_WAIT, MC_DONE), REG_AW default, control-bundle struct {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble}.
- Sub-module load_use_detect: purely combinational lu comparator, instantiated once.

Test Plan:
- Reset: rst=1 for 3 cycles with ex_multicycle=1 -> all enables 0, stall_count=0; after release, state is RUN.
- Load-use: ex_is_load=1, ex_rd=5, id_rs_b=5, id_uses_b=1 -> exactly one cycle of pc_we=0, id_ex_bubble=1, then normal flow; stall_count=1. Same stimulus with ex_rd=0 -> no stall.
- Multi-cycle at MC_LATENCY=4: ex_multicycle held high -> id_ex_we=0 for 4 cycles, busy=1 for 3, ex_mc_done pulses once in cycle 5 with id_ex_we=1; no retrigger; stall_count=4.
- Simultaneous ex_ret_enable=1 with a matching lu -> pc_we=1, if_id_flush=1, id_ex_bubble=1, no stall.
- rst asserted in second MC_WAIT cycle -> next cycle RUN, counters 0, no ex_mc_done pulse.
- stall_count saturation with CNT_W=4: 20 stalled cycles -> stall_count holds 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding,
// the per-cycle stage-register control bundle and a few canned bundles.
package pipe_ctrl_pkg;

    // Default register-address width (32 architectural registers).
    localparam int REG_AW_DEFAULT = 5;

    // RUN     : normal issue, hazards resolved combinationally.
    // MC_WAIT : EX is held while a multi-cycle op finishes.
    // MC_DONE : the multi-cycle result is final this cycle.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    // Controls for the PC and the IF/ID, ID/EX stage registers.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_bubble;
    } ctrl_t;

    // Everything frozen: used in reset and while EX is held.
    localparam ctrl_t CTRL_HOLD = '{
        pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
        id_ex_we: 1'b0, id_ex_bubble: 1'b0
    };

    // Normal flow: every stage advances.
    localparam ctrl_t CTRL_FLOW = '{
        pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
        id_ex_we: 1'b1, id_ex_bubble: 1'b0
    };

    // Redirect: PC takes the new target, the wrong-path instructions in
    // IF/ID and ID/EX are squashed into bubbles.
    localparam ctrl_t CTRL_REDIRECT = '{
        pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
        id_ex_we: 1'b1, id_ex_bubble: 1'b1
    };

    // Load-use: PC and IF/ID hold the consumer, ID/EX takes one bubble.
    localparam ctrl_t CTRL_LOAD_USE = '{
        pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
        id_ex_we: 1'b1, id_ex_bubble: 1'b1
    };

    // Priority resolution shared by RUN and MC_DONE: redirect beats
    // load-use, which beats normal flow. Multi-cycle entry is handled by
    // the caller because only RUN may start a new multi-cycle op.
    function automatic ctrl_t resolve_ctrl(input logic redirect, input logic lu);
        ctrl_t c;
        if (redirect) begin
            c = CTRL_REDIRECT;
        end else if (lu) begin
            c = CTRL_LOAD_USE;
        end else begin
            c = CTRL_FLOW;
        end
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags a decode-stage instruction that
// reads the destination of a load currently in EX. Register 0 is hardwired
// and never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs_a,
    input  logic [REG_AW-1:0] i_id_rs_b,
    input  logic              i_id_uses_a,
    input  logic              i_id_uses_b,
    input  logic              i_ex_valid,
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_ex_rd,
    output logic              o_lu
);

    logic w_load_in_ex;
    logic w_match_a;
    logic w_match_b;

    // Hazard exists only for a real load in EX writing a real register,
    // consumed by a real instruction in ID through an operand it reads.
    always_comb begin
        w_load_in_ex = i_ex_valid && i_ex_is_load && (i_ex_rd != '0);
        w_match_a    = i_id_uses_a && (i_id_rs_a == i_ex_rd);
        w_match_b    = i_id_uses_b && (i_id_rs_b == i_ex_rd);
        o_lu         = i_id_valid && w_load_in_ex && (w_match_a || w_match_b);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the PC, IF/ID and ID/EX registers.
// Resolves redirects, multi-cycle EX holds and load-use hazards into
// per-cycle write-enable / flush / bubble controls, and counts stall cycles.
// State is registered; all controls are combinational from state and inputs.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEFAULT,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rs_b,
    input  logic              id_uses_a,
    input  logic              id_uses_b,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_multicycle,
    input  logic              ex_ret_enable,
    output logic              pc_we,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_we,
    output logic              id_ex_bubble,
    output logic              ex_mc_done,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_count,
    output state_t            dbg_state
);

    // A multi-cycle op occupies the detect cycle plus MC_LATENCY-1 wait
    // cycles, so a latency below 2 would leave no wait phase at all.
    if (MC_LATENCY < 2) begin : g_bad_latency
        $error("pipe_hazard_ctrl: MC_LATENCY must be 2 or more");
    end

    // Counter holds the remaining wait cycles, at most MC_LATENCY-1.
    localparam int MC_CW = (MC_LATENCY < 2) ? 1 : $clog2(MC_LATENCY);
    localparam logic [MC_CW-1:0] MC_LOAD = MC_CW'(MC_LATENCY - 1);
    localparam logic [MC_CW-1:0] MC_ONE  = MC_CW'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [MC_CW-1:0] r_mc_cnt;
    logic [MC_CW-1:0] w_mc_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    ctrl_t            w_ctrl;
    logic             w_lu;
    logic             w_redirect;
    logic             w_mc_start;
    logic             w_mc_done;
    logic             w_busy;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .i_id_valid   (id_valid),
        .i_id_rs_a    (id_rs_a),
        .i_id_rs_b    (id_rs_b),
        .i_id_uses_a  (id_uses_a),
        .i_id_uses_b  (id_uses_b),
        .i_ex_valid   (ex_valid),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .o_lu         (w_lu)
    );

    // EX-originated requests; a bubble in EX (ex_valid=0) requests nothing.
    always_comb begin
        w_redirect = ex_valid && ex_ret_enable;
        w_mc_start = ex_valid && ex_multicycle;
    end

    // Next-state and control decode; reset forces every control low.
    always_comb begin
        w_next_state  = r_state;
        w_mc_cnt_next = r_mc_cnt;
        w_ctrl        = CTRL_HOLD;
        w_mc_done     = 1'b0;
        w_busy        = 1'b0;

        if (rst) begin
            w_next_state  = RUN;
            w_mc_cnt_next = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_redirect) begin
                        w_ctrl = CTRL_REDIRECT;
                    end else if (w_mc_start) begin
                        // Detect cycle counts as the first stalled cycle.
                        w_ctrl        = CTRL_HOLD;
                        w_mc_cnt_next = MC_LOAD;
                        w_next_state  = MC_WAIT;
                    end else begin
                        w_ctrl = resolve_ctrl(1'b0, w_lu);
                    end
                end

                MC_WAIT: begin
                    // EX is busy; decode-side inputs cannot change anything.
                    w_ctrl        = CTRL_HOLD;
                    w_busy        = 1'b1;
                    w_mc_cnt_next = r_mc_cnt - MC_ONE;
                    if (r_mc_cnt == MC_ONE) begin
                        w_next_state = MC_DONE;
                    end
                end

                MC_DONE: begin
                    // The held op may still present ex_multicycle; it is not
                    // re-launched. Its result releases the pipeline now.
                    w_mc_done    = 1'b1;
                    w_ctrl       = resolve_ctrl(w_redirect, w_lu);
                    w_next_state = RUN;
                end

                default: begin
                    w_next_state  = RUN;
                    w_mc_cnt_next = '0;
                end
            endcase
        end
    end

    // State and multi-cycle countdown registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_mc_cnt <= w_mc_cnt_next;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_ctrl.pc_we && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Drive the outputs from the decoded control bundle.
    always_comb begin
        pc_we        = w_ctrl.pc_we;
        if_id_we     = w_ctrl.if_id_we;
        if_id_flush  = w_ctrl.if_id_flush;
        id_ex_we     = w_ctrl.id_ex_we;
        id_ex_bubble = w_ctrl.id_ex_bubble;
        ex_mc_done   = w_mc_done;
        busy         = w_busy;
        stall_count  = r_stall_cnt;
        dbg_state    = r_state;
    end

endmodule
